// File: rtl/mag2c_serial_if.sv
// Operand-in / result-out handshake bundle for the sign-magnitude to
// two's-complement converter.
interface mag2c_serial_if #(
  parameter int MAG_W = 16,
  parameter int OUT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             sign;
  logic [MAG_W-1:0] mag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] Dout;
  logic             ovf;

  modport master (
    output in_valid, sign, mag, out_ready,
    input  in_ready, out_valid, Dout, ovf
  );

  modport slave (
    input  in_valid, sign, mag, out_ready,
    output in_ready, out_valid, Dout, ovf
  );
endinterface

// File: rtl/mag2c_serial.sv
// Serial sign-magnitude to saturated two's-complement converter: negates the
// magnitude LSB first (copy through the first 1, invert the rest).
module mag2c_serial #(
  parameter int MAG_W = 16,
  parameter int OUT_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mag2c_serial_if.slave  bus
);
  localparam int CNT_W = $clog2(MAG_W);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(MAG_W - 1);
  localparam logic [MAG_W-1:0] LIM_NEG = MAG_W'(1) << (OUT_W - 1);
  localparam logic [MAG_W-1:0] LIM_POS = LIM_NEG - MAG_W'(1);
  localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] SAT_POS = ~SAT_NEG;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [MAG_W-1:0] sr;
  logic [MAG_W-1:0] res;
  logic [CNT_W-1:0] cnt;
  logic             sgn;
  logic             seen_one;
  logic             ovf_r;
  logic             bit_in;
  logic             bit_out;
  logic             unused_res_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid)   state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST)    state_nxt = DONE;
      DONE:    if (bus.out_ready)  state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Once a 1 has passed through, every later bit of a negative operand flips.
  assign bit_in  = sr[0];
  assign bit_out = (sgn & seen_one) ? ~bit_in : bit_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr       <= '0;
      res      <= '0;
      cnt      <= '0;
      sgn      <= 1'b0;
      seen_one <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sr       <= bus.mag;
            sgn      <= bus.sign;
            res      <= '0;
            cnt      <= '0;
            seen_one <= 1'b0;
            ovf_r    <= bus.sign ? (bus.mag > LIM_NEG) : (bus.mag > LIM_POS);
          end
        end
        SHIFT: begin
          res      <= {bit_out, res[MAG_W-1:1]};
          sr       <= sr >> 1;
          seen_one <= seen_one | bit_in;
          cnt      <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Full-width negation is kept; only the low OUT_W bits reach the output.
  assign unused_res_hi = ^res[MAG_W-1:OUT_W];

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.Dout      = '0;
    bus.ovf       = 1'b0;
    if (state == DONE) begin
      bus.Dout = ovf_r ? (sgn ? SAT_NEG : SAT_POS) : res[OUT_W-1:0];
      bus.ovf  = ovf_r;
    end
  end
endmodule

// File: tb/tb_mag2c_serial.sv
// Directed scoreboard bench for mag2c_serial: expected results come from an
// integer reference model and are checked when the converter presents them.
module tb_mag2c_serial;
  localparam int MAG_W = 16;
  localparam int OUT_W = 8;

  typedef struct {
    logic [OUT_W-1:0] dout;
    logic             ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   passed = 0;
  int   total  = 0;
  exp_t sb[$];

  mag2c_serial_if #(.MAG_W(MAG_W), .OUT_W(OUT_W)) bus ();

  mag2c_serial #(.MAG_W(MAG_W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic s, input logic [MAG_W-1:0] m);
    exp_t e;
    int   v;
    v = s ? -int'(m) : int'(m);
    if (v > 127)       begin e.dout = 8'h7F; e.ovf = 1'b1; end
    else if (v < -128) begin e.dout = 8'h80; e.ovf = 1'b1; end
    else               begin e.dout = v[7:0]; e.ovf = 1'b0; end
    return e;
  endfunction

  task automatic run_op(input logic s, input logic [MAG_W-1:0] m, input int hold);
    exp_t e;
    int   lat;
    logic [OUT_W-1:0] d0;
    sb.push_back(model(s, m));
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.sign      = s;
    bus.mag       = m;
    bus.out_ready = (hold == 0);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("in_ready_busy", 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'd16);
    e = sb.pop_front();
    check("dout", 32'(bus.Dout), 32'(e.dout));
    check("ovf", 32'(bus.ovf), 32'(e.ovf));
    d0 = bus.Dout;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.sign     = ~s;
      bus.mag      = 16'd1;
      check("hold_dout", 32'(bus.Dout), 32'(d0));
      check("hold_ovf", 32'(bus.ovf), 32'(e.ovf));
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
    end
    if (hold != 0) begin
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("out_valid_drop", 32'(bus.out_valid), 32'd0);
    check("in_ready_back", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int pulses;
    bus.in_valid  = 1'b0;
    bus.sign      = 1'b0;
    bus.mag       = '0;
    bus.out_ready = 1'b1;

    // asynchronous reset between edges
    #3 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_dout", 32'(bus.Dout), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b0, 16'd5, 0);
    run_op(1'b1, 16'd5, 0);
    run_op(1'b1, 16'd128, 0);
    run_op(1'b0, 16'd127, 0);
    run_op(1'b0, 16'd128, 0);
    run_op(1'b1, 16'd300, 0);
    run_op(1'b1, 16'd0, 0);
    run_op(1'b1, 16'h8000, 0);
    run_op(1'b0, 16'hFFFF, 0);
    run_op(1'b1, 16'd77, 0);

    // backpressure: result held for 5 cycles while new operands are offered
    run_op(1'b0, 16'd100, 5);

    // reset in the middle of SHIFT discards the conversion
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.sign      = 1'b1;
    bus.mag       = 16'd9;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_dout", 32'(bus.Dout), 32'd0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (bus.out_valid) pulses++;
    end
    check("no_pulse_after_rst", 32'(pulses), 32'd0);
    run_op(1'b0, 16'd3, 0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mag2c_serial.md
# mag2c_serial

Sequential sign-magnitude to two's-complement converter. It is the inverse of the display path's two's-complement to sign/magnitude conversion. It accepts a sign bit and a 16-bit magnitude, such as a value entered on switches or decoded from a keypad. It negates the magnitude serially, LSB first (copy bits through the first 1, invert the rest), range-checks the result, and returns a saturated 8-bit two's-complement value with an overflow flag. It sits between the operand-entry logic and the 8-bit ALU datapath, using a valid/ready handshake on both sides.

## Interface
- MAG_W, 16, magnitude width; also the number of serial steps.
- OUT_W, 8, two's-complement output width; OUT_W < MAG_W.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand present on sign/mag.
- in_ready  output  1  converter idle, can accept an operand.
- sign  input  1  1 = negative.
- mag  input  MAG_W  unsigned magnitude.
- out_valid  output  1  Dout/ovf valid; held until taken.
- out_ready  input  1  consumer takes the result.
- Dout  output  OUT_W  two's-complement result (saturated on overflow).
- ovf  output  1  magnitude out of OUT_W signed range.

## Operation
- Reset: one clock and an asynchronous active-low reset; reset is asynchronous, active-low (rst_n), and immediate. Reset values: state = IDLE, in_ready = 1, out_valid = 0, Dout = 0, ovf = 0. Internal shift/result registers, counter, and flags are also cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready:
    - latch mag into shift register sr and sign into sgn;
    - clear result register res (MAG_W bits), step counter cnt, and seen_one;
    - compute the overflow flag: ovf_r = sgn ? (mag > 2^(OUT_W-1)) : (mag > 2^(OUT_W-1)-1);
    - go to SHIFT.
- SHIFT (one bit per clock):
  - b = sr[0]; o = (sgn & seen_one) ? ~b : b.
  - res <= {o, res[MAG_W-1:1]}; sr <= sr >> 1; seen_one <= seen_one | b; cnt <= cnt + 1.
  - When cnt = MAG_W-1 on this edge, go to DONE.
- DONE:
  - out_valid = 1.
  - Dout = ovf_r ? (sgn ? 1 followed by OUT_W-1 zeros : 0 followed by OUT_W-1 ones) : res[OUT_W-1:0].
  - ovf = ovf_r.
  - On out_ready, go to IDLE.
- Arithmetic rules:
  - The full MAG_W-bit negation is always performed; truncation to OUT_W bits happens only at output.
  - For OUT_W = 8, in-range values are -128..+127.
- Boundary cases:
  - Negative zero (sign = 1, mag = 0): seen_one never sets, res = 0, so Dout = 0x00 and ovf = 0.
  - sign = 1, mag = 128: Dout = 0x80, ovf = 0. This is the asymmetric limit.
  - sign = 0, mag = 128: Dout = 0x7F, ovf = 1.
- in_valid is ignored outside IDLE. No queuing; the operand must be held by the producer until in_ready.
- Dout and ovf are registered and held stable while out_valid = 1 and out_ready = 0.
- Reset asserted mid-SHIFT or in DONE: the conversion is discarded with no output pulse. Outputs return to reset values immediately (asynchronously).

## Timing
- in_ready is combinational from state (IDLE only).
- Acceptance edge E0. SHIFT occupies edges E1..E_MAG_W. out_valid rises after edge E_MAG_W, i.e. MAG_W cycles (16) after the accept edge.
- Handshake-out happens on the edge where out_valid & out_ready. out_valid falls and in_ready rises after that edge.
- Back-to-back throughput: one conversion per MAG_W + 2 cycles with out_ready tied high.
- If out_ready is already high when DONE is entered, out_valid is high for exactly one cycle.
- No combinational path from in_valid/mag/sign or out_ready to Dout/ovf.

## Test plan
- Reset: assert rst_n = 0 asynchronously between edges. Check in_ready = 1, out_valid = 0, Dout = 0x00, ovf = 0 without waiting for a clock.
- Positive and negative values:
  - sign = 0, mag = 5 → out_valid exactly 16 cycles after accept, Dout = 0x05, ovf = 0.
  - sign = 1, mag = 5 → Dout = 0xFB, ovf = 0.
- Range limits:
  - sign = 1, mag = 128 → 0x80, ovf 0.
  - sign = 0, mag = 127 → 0x7F, ovf 0.
  - sign = 0, mag = 128 → 0x7F, ovf 1.
  - sign = 1, mag = 300 → 0x80, ovf 1.
- Edge operands:
  - sign = 1, mag = 0 → Dout = 0x00, ovf 0.
  - sign = 1, mag = 0x8000 → 0x80, ovf 1.
  - sign = 0, mag = 0xFFFF → 0x7F, ovf 1.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE. Dout/ovf stay stable, in_ready stays 0, and a new in_valid is ignored. Release out_ready: one handshake, then in_ready = 1 on the next cycle.
- Reset mid-operation: accept sign = 1, mag = 9, then pull rst_n low at cycle 8 of SHIFT. No out_valid pulse occurs. After release, a new operand (sign = 0, mag = 3) yields 0x03 after 16 cycles.
